// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types, divide codes and period helper for the tick burst scheduler
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic [1:0] DIV2  = 2'd0;
    localparam logic [1:0] DIV4  = 2'd1;
    localparam logic [1:0] DIV8  = 2'd2;
    localparam logic [1:0] DIV16 = 2'd3;

    function automatic logic [4:0] period(input logic [1:0] code);
        return 5'd2 << code;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - 4-bit wrapping prescaler with registered tick on the last count of the period
module tick_prescaler
    import tick_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] period_sel,
    output logic       tick
);

    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] last;

    always_comb begin
        last     = 4'(period(period_sel) - 5'd1);
        cnt_next = (cnt == last) ? 4'd0 : cnt + 4'd1;
    end

    // tick is registered so it lines up with the cycle where cnt == last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 4'd0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= 4'd0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= cnt_next;
            tick <= (cnt_next == last);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_burst_scheduler.sv
// rtl/tick_burst_scheduler.sv - round-robin owner of a shared divided-tick generator, counts burst ticks
module tick_burst_scheduler
    import tick_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     div_sel,
    input  logic [CNT_W*N_REQ-1:0] burst_len,
    output logic [N_REQ-1:0]       grant,
    output logic                   tick,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [1:0]       div_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] tick_cnt;
    logic             finish;
    logic             abort;
    logic             pre_clr;
    logic             pre_en;

    // walk downward so the requester closest to rr_ptr is the last (winning) assignment
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        owner_nx = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        abort    = !req[owner];
        finish   = (len_q == '0) || (tick && (tick_cnt + 1'b1 == len_q));
    end

    always_comb begin
        state_nx = state;
        pre_clr  = 1'b0;
        pre_en   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = RUN;
                    pre_clr  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (finish) begin
                    state_nx = DONE;
                end else begin
                    pre_en = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // abort takes priority over completion, so a dropped request never sees done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            owner    <= '0;
            div_q    <= 2'd0;
            len_q    <= '0;
            tick_cnt <= '0;
            grant    <= '0;
            done     <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner    <= win_idx;
                        div_q    <= div_sel[int'(win_idx) * 2 +: 2];
                        len_q    <= burst_len[int'(win_idx) * CNT_W +: CNT_W];
                        tick_cnt <= '0;
                        grant    <= N_REQ'(1) << win_idx;
                    end
                end
                RUN: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                    if (state_nx != RUN) begin
                        grant  <= '0;
                        rr_ptr <= owner_nx;
                    end
                    if (state_nx == DONE) begin
                        done <= N_REQ'(1) << owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    tick_prescaler u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pre_clr),
        .en         (pre_en),
        .period_sel (div_q),
        .tick       (tick)
    );

endmodule

// File: tb/tb_tick_burst_scheduler.sv
// tb/tb_tick_burst_scheduler.sv - scoreboard bench: burst-level model predicts grant/tick/done/idle events
module tb_tick_burst_scheduler;
    import tick_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
    localparam int EV_GRANT = 0;
    localparam int EV_TICK  = 1;
    localparam int EV_REL   = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_IDLE  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] div_sel = '0;
    logic [W*N-1:0] burst_len = '0;
    logic [N-1:0]   grant;
    logic           tick;
    logic [N-1:0]   done;
    logic           busy;

    tick_burst_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .div_sel   (div_sel),
        .burst_len (burst_len),
        .grant     (grant),
        .tick      (tick),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int own;
    } ev_t;

    ev_t          q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [N-1:0] pend = '0;
    logic [N-1:0] keep = '0;
    logic [1:0]   fld_div[N];
    int           fld_len[N];
    int           ab_off[N];
    int           m_idle_from = 0;
    int           m_rr = 0;
    int           m_own = 0;
    int           m_g = 0;
    int           m_drop = -1;
    int           m_fin = -1;
    int           n_grants = 0;
    bit           m_act = 1'b0;
    logic [N-1:0] pg;
    logic         pb;

    function automatic string kname(int k);
        case (k)
            EV_GRANT: return "grant";
            EV_TICK:  return "tick";
            EV_REL:   return "release";
            EV_DONE:  return "done";
            default:  return "idle";
        endcase
    endfunction

    function automatic int ohidx(logic [N-1:0] v);
        if (!$onehot(v)) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic push_ev(int c, int k, int o);
        ev_t e;
        e.cyc = c; e.kind = k; e.own = o;
        q.push_back(e);
    endtask

    task automatic check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic observe(int k, int o);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got owner=%0d at cycle %0d, required no event", kname(k), o, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.own != o || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event_%s: got %s owner=%0d cycle=%0d, required %s owner=%0d cycle=%0d",
                         kname(k), kname(k), o, cyc, kname(e.kind), e.own, e.cyc);
            end
        end
    endtask

    task automatic monitor();
        ev_t e;
        pg = '0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pg = '0;
                pb = 1'b0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_%s: got nothing by cycle %0d, required owner=%0d at cycle %0d",
                             kname(e.kind), cyc, e.own, e.cyc);
                end
                if (grant != '0) begin
                    n_cmp++;
                    if (!$onehot(grant) || (pg != '0 && pg != grant)) begin
                        n_bad++;
                        $display("FAIL grant_shape: got %b after %b, required stable one-hot", grant, pg);
                    end
                end
                if (busy && !pb) begin
                    n_cmp++;
                    if (grant == '0 || pg != '0) begin
                        n_bad++;
                        $display("FAIL busy_rise: got grant %b at cycle %0d, required a new grant", grant, cyc);
                    end
                end
                if (grant != '0 && pg == '0) observe(EV_GRANT, ohidx(grant));
                if (tick)                    observe(EV_TICK, 0);
                if (grant == '0 && pg != '0) observe(EV_REL, 0);
                if (done != '0)              observe(EV_DONE, ohidx(done));
                if (!busy && pb)             observe(EV_IDLE, 0);
                pg = grant;
                pb = busy;
            end
        end
    endtask

    task automatic model_grant(int c);
        int w, g, p, l, run, a;
        w = 0;
        for (int k = N - 1; k >= 0; k--) if (pend[(m_rr + k) % N]) w = (m_rr + k) % N;
        g   = c + 1;
        p   = 2 ** (int'(fld_div[w]) + 1);
        l   = fld_len[w];
        run = (l == 0) ? 1 : l * p;
        push_ev(g, EV_GRANT, w);
        if (ab_off[w] >= 0 && ab_off[w] < run) begin
            a = g + ab_off[w];
            for (int k = 1; k <= l; k++) if (g + k * p - 1 <= a) push_ev(g + k * p - 1, EV_TICK, 0);
            push_ev(a + 1, EV_REL, 0);
            push_ev(a + 1, EV_IDLE, 0);
            m_idle_from = a + 1;
            m_drop = a;
            m_fin = -1;
        end else begin
            for (int k = 1; k <= l; k++) push_ev(g + k * p - 1, EV_TICK, 0);
            push_ev(g + run, EV_REL, 0);
            push_ev(g + run, EV_DONE, w);
            push_ev(g + run + 1, EV_IDLE, 0);
            m_idle_from = g + run + 1;
            m_fin = g + run;
            m_drop = -1;
        end
        m_act = 1'b1;
        m_own = w;
        m_g = g;
        m_rr = (w + 1) % N;
        n_grants++;
        ab_off[w] = -1;
        if (!keep[w]) begin
            fld_div[w] = 2'($urandom_range(0, 3));
            fld_len[w] = $urandom_range(0, 255);
        end
    endtask

    task automatic cycle_body();
        int c;
        c = cyc;
        if (m_act && c == m_drop) begin
            pend[m_own] = 1'b0;
            m_act = 1'b0;
        end
        if (m_act && c == m_fin) begin
            if (!keep[m_own]) pend[m_own] = 1'b0;
            m_act = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                fld_div[i] = 2'($urandom_range(0, 3));
                fld_len[i] = $urandom_range(0, 255);
            end
            div_sel[2*i +: 2]   = fld_div[i];
            burst_len[W*i +: W] = W'(fld_len[i]);
        end
        req = pend;
        if (rst_n && c >= m_idle_from && pend != '0) model_grant(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle_body();
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_idle_from = cyc;
        m_rr = 0;
        m_act = 1'b0;
        m_drop = -1;
        m_fin = -1;
        cycle_body();
    endtask

    task automatic raise(int i, logic [1:0] d, int l, int ab);
        pend[i] = 1'b1;
        fld_div[i] = d;
        fld_len[i] = l;
        ab_off[i] = ab;
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while ((q.size() > 0 || pend != '0 || m_act) && n < budget) begin
            step();
            n++;
        end
        check({name, "_in_budget"}, int'(n < budget), 1);
    endtask

    initial begin
        int d, l, run, ab, tgt, n;
        for (int i = 0; i < N; i++) begin
            fld_div[i] = DIV2;
            fld_len[i] = 0;
            ab_off[i]  = -1;
        end
        fork
            monitor();
        join_none

        for (int i = 0; i < N; i++) raise(i, DIV2, 1, -1);
        repeat (3) step();
        check("reset_grant", int'(grant), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        release_rst();
        drain("reset_all_req", 400);

        keep = 4'b1011;
        raise(0, DIV4, 1, -1);
        raise(1, DIV4, 1, -1);
        raise(3, DIV4, 1, -1);
        tgt = n_grants + 4;
        n = 0;
        while (n_grants < tgt && n < 200) begin
            step();
            n++;
        end
        keep = '0;
        drain("round_robin", 400);

        raise(2, DIV2, 3, -1);
        drain("single_div2", 100);

        raise(1, DIV8, 0, -1);
        drain("zero_len", 100);

        raise(0, DIV16, 5, 20);
        step();
        raise(1, DIV2, 2, -1);
        drain("abort", 300);

        raise(3, DIV8, 3, -1);
        step();
        n = 0;
        while (cyc < m_g + 7 && n < 50) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        q.delete();
        pend = '0;
        keep = '0;
        m_act = 1'b0;
        #1;
        check("midrst_tick", int'(tick), 0);
        check("midrst_grant", int'(grant), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) step();
        release_rst();
        drain("after_midrst", 50);

        raise(2, DIV2, 255, -1);
        drain("max_len", 700);

        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) == 0) begin
                    d   = $urandom_range(0, 3);
                    l   = $urandom_range(0, 6);
                    run = (l == 0) ? 1 : l * (2 ** (d + 1));
                    ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, run)) : -1;
                    raise(i, 2'(d), l, ab);
                end
            end
            step();
        end
        drain("random", 1000);
        repeat (4) step();
        check("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_burst_scheduler.md
# tick_burst_scheduler

Round-robin scheduler that shares one programmable divided-tick generator among `N_REQ` requesters. A requester asks for a burst of `burst_len` ticks at a selected divide ratio (/2, /4, /8, /16). The scheduler grants one requester at a time, sequences the prescaler for it, counts delivered ticks, and signals completion. It sits between the peripheral timing clients and the shared clock-enable datapath.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 8, width of each burst-length field
- `clk` input 1, single system clock
- `rst_n` input 1, asynchronous active-low reset
- `req` input N_REQ, per-requester request level; held high until `done` or abort
- `div_sel` input 2*N_REQ, per-requester divide code, field i = bits [2i+1:2i]; 0=/2, 1=/4, 2=/8, 3=/16
- `burst_len` input CNT_W*N_REQ, per-requester tick count, field i = bits [CNT_W*(i+1)-1:CNT_W*i]
- `grant` output N_REQ, one-hot (or zero) owner of the tick generator
- `tick` output 1, one-cycle clock-enable strobe for the granted requester
- `done` output N_REQ, one-cycle completion pulse to the owner
- `busy` output 1, high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner by round-robin, searching upward from `rr_ptr` and wrapping.
  - Latch the winner's `div_sel` and `burst_len`, clear the prescaler and tick counter, set `grant[winner]`, and go to RUN.
- RUN:
  - Period P = 2^(div_sel+1).
  - The prescaler counts 0..P-1 and wraps.
  - `tick` is high in each cycle where prescaler == P-1.
  - The tick counter increments on each tick.
  - When the counter reaches the latched `burst_len`, go to DONE.
- DONE:
  - `done[owner]` is high for this cycle; `grant` is low.
  - Set `rr_ptr` to owner+1 (mod N_REQ).
  - Go to IDLE.
- `burst_len` == 0:
  - The requester is granted, RUN lasts exactly one cycle with no tick, then DONE.
- Abort: if `req[owner]` drops during RUN:
  - Any `tick` in that same cycle is still issued.
  - Go to IDLE the next cycle with no `done` pulse.
  - `grant` clears and `rr_ptr` advances past the owner.
- Input changes after grant have no effect: `div_sel` and `burst_len` are used only from their latched copies.
- Width rules:
  - Prescaler is 4 bits.
  - Tick counter is CNT_W bits and never wraps, since bursts terminate at `burst_len` ≤ 2^CNT_W-1.
- Reset mid-operation clears everything immediately; there is no `done` pulse and the burst is lost.

## Timing
- Reset values: `grant`=0, `tick`=0, `done`=0, `busy`=0, state=IDLE, `rr_ptr`=0 (`req[0]` has highest priority after reset).
- All outputs are driven from flops with no combinational input-to-output paths.
- `req` high in IDLE at cycle T gives `grant` high at T+1 (cycle G).
- First tick is at G+P-1; tick k (1-based) is at G+kP-1.
- The last tick is at G+L·P-1, where L is the latched `burst_len`.
- `done` pulses at G+L·P, and `grant` is low in that same cycle.
- IDLE is at G+L·P+1, so the earliest next grant is G+L·P+2.
- Simultaneous requests: exactly one grant; the others wait, and `req` must be held.

## Structure
- Shared package `tick_sched_pkg`:
  - state enum (IDLE, RUN, DONE)
  - divide-code constants `DIV2`, `DIV4`, `DIV8`, `DIV16`
  - period function returning 2^(code+1)
- One sub-module, `tick_prescaler`:
  - 4-bit counter with synchronous clear and enable
  - `period_sel` input and `tick` output
  - instantiated once inside the scheduler
- The scheduler holds the FSM, the round-robin arbiter, the latches and the tick counter.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111, then release. Required: all outputs 0 during reset; first `grant`=4'b0001.
- Single /2 burst: `req[2]`=1, `div_sel[2]`=0, `burst_len[2]`=3. Required: ticks at G+1, G+3 and G+5; `done[2]` at G+6; `grant` low at G+6.
- Round-robin: `req`=4'b1011 held constant, each with /4 and length 1. Required: grant order 0,1,3,0; each `done` at G+4.
- Zero length: `burst_len[1]`=0. Required: `grant[1]` for one cycle, no tick, `done[1]` at G+1.
- Abort: /16 with length 5; drop `req[0]` at G+20, just after the tick at G+15. Required: `grant` low at G+21, no `done`, no further ticks; `req[1]` pending is granted at G+22.
- Reset mid-burst: assert `rst_n`=0 at G+7 of a /8 burst. Required: `tick`, `grant` and `busy` go to 0 asynchronously; no `done`.
